// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - data-memory stage sequencer with req/ack port, lane steering and access traps
//
// Ports:
//   Clock, Reset           rising-edge clock, synchronous active-high reset
//   Rmem, Wmem             load / store request from the EXE/MEM register
//   func3                  RV32I load/store width code
//   result                 effective byte address
//   rs2                    store data
//   mem_req, mem_we        registered request / write strobe of the single-outstanding memory port
//   mem_addr               registered word address
//   mem_wdata, mem_be      registered lane-replicated store data and byte enables
//   mem_ack, mem_rdata     memory completion and read word
//   stall                  holds PC and pipeline registers up to EXE/MEM while an access is in flight
//   load_data, load_valid  registered extended load result, valid for one cycle
//   fault, fault_addr      one-cycle access exception and the faulting byte address

module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Rmem,
    input  logic        Wmem,
    input  logic [2:0]  func3,
    input  logic [31:0] result,
    input  logic [31:0] rs2,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        fault,
    output logic [31:0] fault_addr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [15:0] wait_cnt;
    logic [2:0]  func3_q;
    logic [31:0] byte_addr_q;
    logic        is_read_q;
    logic        abort_q;

    logic        access;
    logic        legal;
    logic        ld_code_ok;
    logic        st_code_ok;
    logic        align_ok;
    logic        issue;
    logic        bad_access;
    logic        abort_fault;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign access = Rmem | Wmem;

    always_comb begin
        ld_code_ok = func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        st_code_ok = func3 inside {3'b000, 3'b001, 3'b010};
        case (func3[1:0])
            2'b01:   align_ok = ~result[0];
            2'b10:   align_ok = (result[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        legal = ~(Rmem & Wmem) & (~Rmem | ld_code_ok) & (~Wmem | st_code_ok) & align_ok;
    end

    assign issue       = (state == S_IDLE) & access & legal;
    assign bad_access  = (state == S_IDLE) & access & ~legal;
    assign abort_fault = (state == S_DONE) & abort_q;

    // Stall covers the issue cycle too, so EXE/MEM stays put until DONE.
    assign stall      = issue | (state == S_WAIT);
    assign fault      = bad_access | abort_fault;
    assign fault_addr = bad_access  ? result :
                        abort_fault ? byte_addr_q : 32'h0;

    // Store lane steering; replicate the datum so every enabled lane sees it.
    always_comb begin
        wr_be   = 4'b1111;
        wr_data = rs2;
        case (func3[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << result[1:0];
                wr_data = {4{rs2[7:0]}};
            end
            2'b01: begin
                wr_be   = result[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{rs2[15:0]}};
            end
            default: ;
        endcase
        if (Rmem) begin
            wr_be = 4'b1111;
        end
    end

    // Load lane extraction from the word returned with mem_ack.
    always_comb begin
        case (byte_addr_q[1:0])
            2'b00:   ld_byte = mem_rdata[7:0];
            2'b01:   ld_byte = mem_rdata[15:8];
            2'b10:   ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = byte_addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (func3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= S_IDLE;
            wait_cnt    <= 16'h0;
            func3_q     <= 3'b000;
            byte_addr_q <= 32'h0;
            is_read_q   <= 1'b0;
            abort_q     <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wdata   <= 32'h0;
            mem_be      <= 4'b0000;
            load_data   <= 32'h0;
            load_valid  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    load_valid <= 1'b0;
                    if (issue) begin
                        mem_addr    <= {result[31:2], 2'b00};
                        mem_we      <= Wmem;
                        mem_be      <= wr_be;
                        mem_wdata   <= wr_data;
                        func3_q     <= func3;
                        byte_addr_q <= result;
                        is_read_q   <= Rmem;
                        wait_cnt    <= 16'h0;
                        abort_q     <= 1'b0;
                        mem_req     <= 1'b1;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // An ack on the final counted cycle takes priority over the abort.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= S_DONE;
                        if (is_read_q) begin
                            load_data  <= ld_ext;
                            load_valid <= 1'b1;
                        end
                    end else if (wait_cnt == CNT_LAST) begin
                        mem_req <= 1'b0;
                        abort_q <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    // EXE/MEM still holds this access; returning to IDLE without
                    // re-sampling it keeps it from being issued twice.
                    load_valid <= 1'b0;
                    abort_q    <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the data-memory stage of the pipelined core. Takes the access fields held in the EXE/MEM pipeline register and drives a single-outstanding req/ack data-memory port. Generates byte enables and lane-replicated store data, and extracts and sign- or zero-extends load data. Stalls the pipeline while an access is in flight, and flags misaligned, illegal and timed-out accesses to the trap logic.

## Interface
- TIMEOUT, 255: max WAIT cycles without mem_ack before abort (1..65535)
- Clock  in  1  rising-edge clock
- Reset  in  1  one clock; reset is synchronous and active-high
- Rmem  in  1  load request from EXE/MEM register
- Wmem  in  1  store request from EXE/MEM register
- func3  in  3  RV32I load/store width code
- result  in  32  effective byte address
- rs2  in  32  store data
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = write, registered
- mem_addr  out  32  word address {result[31:2],2'b00}, registered
- mem_wdata  out  32  lane-replicated store data, registered
- mem_be  out  4  byte enables, registered
- mem_ack  in  1  memory completion; mem_rdata valid this cycle for reads
- mem_rdata  in  32  read word
- stall  out  1  hold PC and all pipeline registers up to and including EXE/MEM (combinational)
- load_data  out  32  extended load result, registered
- load_valid  out  1  load_data valid (DONE only)
- fault  out  1  access exception pulse (combinational)
- fault_addr  out  32  faulting byte address

## Operation
- FSM states: IDLE, WAIT, DONE.
- access = Rmem | Wmem.
- legal requires all of the following:
  - not (Rmem & Wmem);
  - for loads, func3 ∈ {000,001,010,100,101};
  - for stores, func3 ∈ {000,001,010};
  - alignment: half needs result[0]=0, word needs result[1:0]=00.
- IDLE with access & legal:
  - stall=1;
  - register mem_addr/mem_we/mem_be/mem_wdata, func3 and result[1:0];
  - clear the timeout counter;
  - go to WAIT.
- IDLE with access & !legal:
  - fault=1 and fault_addr=result in that cycle;
  - stall=0, no request, stay IDLE.
- WAIT:
  - mem_req=1 and stall=1; address, data and enables are stable.
  - On mem_ack: capture the extended mem_rdata (reads), go to DONE.
  - Otherwise the counter increments. When counter == TIMEOUT-1 without ack, go to DONE with an abort flag.
- DONE:
  - stall=0 and mem_req=0.
  - load_valid=1 if the access was a read and was not aborted.
  - On abort: fault=1, fault_addr=registered byte address, load_valid=0.
  - Always go to IDLE next cycle. The still-present EXE/MEM fields are not reissued.
- Store lanes, with o = result[1:0]:
  - sb: be=4'b0001<<o, wdata={4{rs2[7:0]}}.
  - sh: be=o[1]?1100:0011, wdata={2{rs2[15:0]}}.
  - sw: be=1111, wdata=rs2.
- Reads drive be=1111 and mem_we=0.
- Load extract: byte lane o, or half lane o[1].
  - lb and lh sign-extend; lbu and lhu zero-extend; lw passes the word through.
- mem_ack outside WAIT is ignored.

## Timing
- Reset values: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_be 0, load_data 0, load_valid 0, counter 0.
- Combinational outputs with access deasserted after reset: stall 0, fault 0, fault_addr 0.
- Minimum access is 3 cycles: IDLE (issue) → WAIT (ack same cycle) → DONE.
- Each extra wait cycle adds 1. stall is high for the IDLE-issue and all WAIT cycles.
- Back-to-back accesses: the next instruction is sampled in IDLE the cycle after DONE, so there is no bubble beyond DONE.
- Reset during WAIT: mem_req low on the following edge, no fault, no load_valid.
- mem_ack on the same edge as timeout: ack wins, and the access completes normally.
- fault is a one-cycle pulse per event and never coincides with mem_req.

## Test plan
- lw at 0x100, mem_ack in the first WAIT cycle with rdata 0xDEADBEEF:
  - mem_req high for exactly 1 cycle with mem_addr 0x100 and be 1111;
  - stall high for 2 cycles;
  - DONE shows load_valid=1 and load_data 0xDEADBEEF.
- lb at 0x203 and lbu at 0x203, rdata 0x80FFFFFF:
  - lb gives load_data 0xFFFFFF80;
  - lbu gives 0x00000080.
- Store half:
  - sh at 0x102 with rs2 0x1234ABCD → mem_we=1, be 1100, wdata 0xABCDABCD, mem_addr 0x100.
- Store byte:
  - sb at 0x101 with the same rs2 → be 0010, wdata 0xCDCDCDCD.
- Misaligned and illegal accesses:
  - lw at 0x102 → fault pulse in the same cycle, fault_addr 0x102, no mem_req, stall 0.
  - Rmem & Wmem together → fault.
  - store with func3 100 → fault.
- TIMEOUT=4 with no ack:
  - mem_req high for 4 cycles, then DONE;
  - fault=1 with fault_addr equal to the byte address, load_valid=0, then IDLE.
- Reset asserted during the 2nd WAIT cycle:
  - next cycle all outputs are at reset values and there is no fault;
  - a subsequent lw completes normally.
